// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, data-length limits and
// the parity mode encoding used by both the transmit and receive paths.
package uart_pkg;

    // TX frame sequencer states (7 states, 3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP1  = 3'd5,
        ST_STOP2  = 3'd6
    } tx_state_t;

    localparam int unsigned UART_DATA_MIN = 5;
    localparam int unsigned UART_DATA_MAX = 8;

    // Parity mode, common to TX and RX configuration
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    function automatic parity_mode_t parity_mode(input logic en, input logic odd);
        parity_mode_t m;
        if (!en) begin
            m = PAR_NONE;
        end else if (odd) begin
            m = PAR_ODD;
        end else begin
            m = PAR_EVEN;
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_processor.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start bit, 5..DATA_MAX data bits LSB-first, optional parity, 1 or 2 stop
// bits. Every bit boundary is aligned to the single-clk baud strobe.
module uart_tx_processor
    import uart_pkg::*;
#(
    parameter int unsigned DATA_MAX   = UART_DATA_MAX,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bd_tick,
    input  logic                tx_valid,
    input  logic [DATA_MAX-1:0] tx_data,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                two_stop,
    input  logic [3:0]          data_len,
    output logic                tx_ready,
    output logic                tx,
    output logic                tx_done,
    output logic                busy
);

    localparam int unsigned CNT_W   = $clog2(DATA_MAX);
    localparam logic [3:0]  MIN_LEN = 4'(UART_DATA_MIN);
    localparam logic [3:0]  MAX_LEN = 4'(DATA_MAX);

    tx_state_t           state_q;
    logic [DATA_MAX-1:0] shift_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    last_idx_q;
    parity_mode_t        par_mode_q;
    logic                par_bit_q;
    logic                two_stop_q;
    logic                tx_q;
    logic                tx_done_q;

    logic [3:0]          len_c;
    logic [CNT_W-1:0]    last_idx_c;
    logic                par_c;

    // Clamp the requested length and compute parity over the bits actually sent
    always_comb begin
        len_c = data_len;
        if (data_len < MIN_LEN) begin
            len_c = MIN_LEN;
        end else if (data_len > MAX_LEN) begin
            len_c = MAX_LEN;
        end
        last_idx_c = CNT_W'(len_c - 4'd1);
        par_c = 1'b0;
        for (int unsigned i = 0; i < DATA_MAX; i++) begin
            if (i < 32'(len_c)) begin
                par_c = par_c ^ tx_data[i];
            end
        end
        par_c = par_c ^ parity_odd;
    end

    // Frame sequencer: one state advance per baud strobe, tx registered with state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= IDLE_LEVEL;
                    if (tx_valid) begin
                        shift_q    <= tx_data;
                        last_idx_q <= last_idx_c;
                        par_mode_q <= parity_mode(parity_en, parity_odd);
                        par_bit_q  <= par_c;
                        two_stop_q <= two_stop;
                        state_q    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (bd_tick) begin
                        state_q <= ST_START;
                        tx_q    <= ~IDLE_LEVEL;
                    end
                end
                ST_START: begin
                    if (bd_tick) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bd_tick) begin
                        if (cnt_q == last_idx_q) begin
                            if (par_mode_q != PAR_NONE) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= ST_STOP1;
                                tx_q    <= IDLE_LEVEL;
                            end
                        end else begin
                            // next bit is driven from shift_q[1] so tx lands with the shift
                            shift_q <= shift_q >> 1;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bd_tick) begin
                        state_q <= ST_STOP1;
                        tx_q    <= IDLE_LEVEL;
                    end
                end
                ST_STOP1: begin
                    if (bd_tick) begin
                        tx_q <= IDLE_LEVEL;
                        if (two_stop_q) begin
                            state_q <= ST_STOP2;
                        end else begin
                            state_q   <= ST_IDLE;
                            tx_done_q <= 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (bd_tick) begin
                        state_q   <= ST_IDLE;
                        tx_q      <= IDLE_LEVEL;
                        tx_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

endmodule

// File: doc/uart_tx_processor.md
Name: uart_tx_processor

Overview:
UART transmitter, the transmit-side counterpart of the UART receive path (UART_processor). It accepts one data word per valid/ready handshake and serialises it LSB-first onto the tx line. Each frame is start bit, 5-8 data bits, optional even/odd parity, then 1 or 2 stop bits. Bit timing is taken from a one-clk-wide baud strobe produced from clock_handler's baud output, so the whole block runs on the single system clock.

Parameters:
DATA_MAX, 8, maximum data bits per frame; width of tx_data.
IDLE_LEVEL, 1'b1, line level driven on tx when idle and during stop bits.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
bd_tick  input  1  baud strobe; high for one clk per bit period
tx_valid  input  1  data word offered
tx_data  input  DATA_MAX  word to send; bit 0 is sent first
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits
data_len  input  4  number of data bits, legal range 5..8
tx_ready  output  1  block can accept a word
tx  output  1  serial line
tx_done  output  1  one-clk pulse when a frame completes
busy  output  1  frame in progress

Behaviour:
- Reset: while rst==0 at a posedge, the next state is IDLE. tx=IDLE_LEVEL, tx_ready=1, busy=0, tx_done=0. All latched configuration and shift data are cleared.
- Reset mid-frame: the frame is abandoned and tx returns to 1 on the next clk. Nothing is resumed.
- Handshake: a word is accepted when tx_valid && tx_ready at a posedge. tx_ready is 1 only in IDLE. On acceptance, tx_data, parity_en, parity_odd, two_stop and data_len are latched into internal registers. Later changes to these inputs have no effect on the frame in flight. tx_valid is ignored while tx_ready==0.
- data_len clamp: values below 5 are treated as 5; values above DATA_MAX are treated as DATA_MAX.
- Parity: computed as the XOR of the data bits actually sent (clamped length only). Even parity sends that XOR; odd parity sends its inverse.
- States: IDLE -> ALIGN -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - IDLE: tx=1. On acceptance, go to ALIGN.
  - ALIGN: tx=1, busy=1. On bd_tick, go to START. This guarantees the start bit lasts a full bit period.
  - START: tx=0. On bd_tick, go to DATA with bit count 0.
  - DATA: tx = shift[0]. On bd_tick, shift right and increment the count. After the last bit (count == len-1), go to PARITY if enabled, else STOP1.
  - PARITY: tx = parity bit. On bd_tick, go to STOP1.
  - STOP1: tx=1. On bd_tick, go to STOP2 if two_stop, else to IDLE.
  - STOP2: tx=1. On bd_tick, go to IDLE.
- Outputs are registered. tx changes on the clk after the bd_tick that ends the previous bit. Every bit from START onward therefore lasts exactly one bd_tick interval.
- tx_done is high for exactly one clk, on the clk where the state returns to IDLE. In that same cycle tx_ready=1 and busy=0.
- Back-to-back frames: a word can be accepted in the same clk tx_done is high. The next frame then starts at the following bd_tick, with no idle gap beyond the ALIGN wait.
- Ticks: a bd_tick asserted in the acceptance cycle is not used, since the state is still IDLE. At most one state advance happens per bd_tick.
- Line level: tx never glitches. It is held constant between bd_ticks.

Decomposition:
- Shared package uart_pkg, holding:
  - the state encoding enum for the TX FSM (7 states, 3 bits);
  - the constants UART_DATA_MIN=5 and UART_DATA_MAX=8;
  - the parity mode encoding, shared with UART_processor.
- Sub-module uart_baud_counter: counts clk between bd_tick for the bench-side checker. It is not needed in the RTL.
- The RTL itself is a single FSM plus a shift register and a 3-bit counter. No sub-module is required.

Test Plan:
1. bd_tick every 16 clk; send 0x55, 8N1 -> tx = 0,1,0,1,0,1,0,1,0,1 with each bit 16 clk long, then a tx_done pulse; tx_ready returns to 1.
2. 0x07, 8 bits, even parity, two_stop=1 -> data 1,1,1,0,0,0,0,0, parity=1, two stop bits of 16 clk each; busy=1 throughout.
3. 0x07, odd parity -> parity bit 0. 0xFF with data_len=7 and even parity -> 7 ones sent, parity=1, bit 7 never driven.
4. data_len=3 -> 5 bits sent. data_len=12 -> 8 bits sent.
5. tx_valid held high with 0xA5 then 0x3C -> both frames sent in order. The second is accepted in its tx_done cycle. tx_data changes mid-frame do not corrupt the first frame.
6. rst=0 asserted during DATA bit 3 -> the next clk shows tx=1, tx_ready=1, busy=0, no tx_done. A new frame sent afterwards is correct.
